// File: rtl/vram_text_fetch_if.sv
// VRAM read port and character-cell output stream of vram_text_fetch.
// Cursor signals exist only when VRAM_FETCH_CURSOR_EN is defined.
interface vram_text_fetch_if;
    logic        vram_en;
    logic        vram_we;
    logic [14:0] vram_addr;
    logic [7:0]  vram_din;
    logic [7:0]  vram_dout;
    logic        cell_valid;
    logic        cell_ready;
    logic [15:0] cell_data;
`ifdef VRAM_FETCH_CURSOR_EN
    logic        cell_cursor;
    logic [14:0] cursor_addr;

    modport master (
        output vram_en, vram_we, vram_addr, vram_din,
        input  vram_dout,
        output cell_valid, cell_data, cell_cursor,
        input  cell_ready, cursor_addr
    );

    modport slave (
        input  vram_en, vram_we, vram_addr, vram_din,
        output vram_dout,
        input  cell_valid, cell_data, cell_cursor,
        output cell_ready, cursor_addr
    );
`else
    modport master (
        output vram_en, vram_we, vram_addr, vram_din,
        input  vram_dout,
        output cell_valid, cell_data,
        input  cell_ready
    );

    modport slave (
        input  vram_en, vram_we, vram_addr, vram_din,
        output vram_dout,
        input  cell_valid, cell_data,
        output cell_ready
    );
`endif
endinterface

// File: rtl/vram_text_fetch.sv
// Text-mode cell fetcher: reads {char, attr} byte pairs from VRAM into a 2-entry FWFT FIFO.
// Optional feature macro VRAM_FETCH_CURSOR_EN adds a per-cell cursor flag.
module vram_text_fetch #(
    parameter int VRAM_WORDS = 8192
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [14:0]       start_addr,
    input  logic [7:0]        cell_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    vram_text_fetch_if.master bus
);
    localparam logic [14:0] ADDR_MASK = 15'(VRAM_WORDS - 1);
`ifdef VRAM_FETCH_CURSOR_EN
    localparam int ENTRY_W = 17;
`else
    localparam int ENTRY_W = 16;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHAR = 2'd1,
        ST_ATTR = 2'd2,
        ST_PUSH = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [14:0]        ptr_r, ptr_s;
    logic [7:0]         rem_r, rem_s;
    logic [7:0]         char_r, char_s;
    logic               done_r, done_s;
    logic               busy_r;
    logic               vram_en_r, vram_en_s;
    logic [14:0]        vram_addr_r, vram_addr_s;
    logic               push_s, pop_s;
    logic [1:0]         occ_r, occ_s;
    logic               valid_r;
    logic [ENTRY_W-1:0] head_r, head_s, tail_r, tail_s, entry_s;

`ifdef VRAM_FETCH_CURSOR_EN
    logic               cur_flag_r;

    // Cursor match is taken when the char read is issued, so it travels with that cell.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_flag_r <= 1'b0;
        end else if (state_r == ST_CHAR && occ_r < 2'd2) begin
            cur_flag_r <= (ptr_r == (bus.cursor_addr & ADDR_MASK));
        end else begin
            cur_flag_r <= cur_flag_r;
        end
    end

    assign entry_s         = {cur_flag_r, bus.vram_dout, char_r};
    assign bus.cell_cursor = head_r[16];
`else
    assign entry_s         = {bus.vram_dout, char_r};
`endif

    // FSM next state, pointer/count bookkeeping and FIFO push request.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        rem_s   = rem_r;
        char_s  = char_r;
        done_s  = 1'b0;
        push_s  = 1'b0;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ptr_s = start_addr & ADDR_MASK;
                        rem_s = cell_count;
                        if (cell_count != 8'd0) begin
                            state_s = ST_CHAR;
                        end else begin
                            done_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_CHAR: begin
                    if (occ_r < 2'd2) begin
                        state_s = ST_ATTR;
                    end else begin
                        state_s = ST_CHAR;
                    end
                end
                ST_ATTR: begin
                    char_s  = bus.vram_dout;
                    state_s = ST_PUSH;
                end
                ST_PUSH: begin
                    push_s = 1'b1;
                    ptr_s  = (ptr_r + 15'd2) & ADDR_MASK;
                    rem_s  = rem_r - 8'd1;
                    if (rem_r == 8'd1) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_CHAR;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Two-entry shift FIFO: head is always the presented cell.
    always_comb begin
        occ_s  = occ_r;
        head_s = head_r;
        tail_s = tail_r;
        pop_s  = (occ_r != 2'd0) && bus.cell_ready;
        case ({push_s, pop_s})
            2'b10: begin
                if (occ_r == 2'd0) begin
                    head_s = entry_s;
                    occ_s  = 2'd1;
                end else begin
                    tail_s = entry_s;
                    occ_s  = 2'd2;
                end
            end
            2'b01: begin
                if (occ_r == 2'd2) begin
                    head_s = tail_r;
                    occ_s  = 2'd1;
                end else begin
                    occ_s  = 2'd0;
                end
            end
            2'b11: begin
                if (occ_r == 2'd2) begin
                    head_s = tail_r;
                    tail_s = entry_s;
                end else begin
                    head_s = entry_s;
                end
            end
            default: begin
                occ_s = occ_r;
            end
        endcase
        if (abort) begin
            occ_s = 2'd0;
        end else begin
            occ_s = occ_s;
        end
    end

    // Read port is registered one cycle ahead: it reflects what the next state will issue.
    always_comb begin
        vram_en_s   = 1'b0;
        vram_addr_s = ptr_s;
        case (state_s)
            ST_CHAR: begin
                vram_en_s = (occ_s < 2'd2);
            end
            ST_ATTR: begin
                vram_en_s   = 1'b1;
                vram_addr_s = (ptr_s + 15'd1) & ADDR_MASK;
            end
            default: begin
                vram_en_s = 1'b0;
            end
        endcase
    end

    // Control state, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 15'd0;
            rem_r       <= 8'd0;
            char_r      <= 8'd0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            vram_en_r   <= 1'b0;
            vram_addr_r <= 15'd0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            rem_r       <= rem_s;
            char_r      <= char_s;
            done_r      <= done_s;
            busy_r      <= (state_s != ST_IDLE);
            vram_en_r   <= vram_en_s;
            vram_addr_r <= vram_addr_s;
        end
    end

    // FIFO storage and valid flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_r   <= 2'd0;
            valid_r <= 1'b0;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            occ_r   <= occ_s;
            valid_r <= (occ_s != 2'd0);
            head_r  <= head_s;
            tail_r  <= tail_s;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign bus.vram_en    = vram_en_r;
    assign bus.vram_addr  = vram_addr_r;
    assign bus.vram_we    = 1'b0;
    assign bus.vram_din   = 8'h00;
    assign bus.cell_valid = valid_r;
    assign bus.cell_data  = head_r[15:0];
endmodule

// File: tb/tb_vram_text_fetch.sv
// Bench for vram_text_fetch: table-driven runs, directed corner sequences and random runs,
// all checked against an address/data model computed from the VRAM image.
module tb_vram_text_fetch;
    localparam int W = 8192;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [14:0] start_addr;
    logic [7:0]  cell_count;
    logic        abort;
    logic        busy;
    logic        done;

    vram_text_fetch_if bus_if ();

    vram_text_fetch #(.VRAM_WORDS(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .cell_count (cell_count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .bus        (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [0:W-1];
    int          total = 0;
    int          bad = 0;
    int          ready_mode = 0;
    int          done_cnt = 0;
    int          vcnt = 0;
    int          stab_bad = 0;
    int          we_bad = 0;
    logic [14:0] rd_q [$];
    logic [15:0] rx_q [$];
    bit          cur_q [$];
    logic        prev_hold = 1'b0;
    logic [15:0] prev_data = 16'h0000;

    // Registered-read VRAM image.
    always @(posedge clk) begin
        if (bus_if.vram_en === 1'b1) bus_if.vram_dout <= mem[bus_if.vram_addr[12:0]];
    end

    // Consumer ready pattern: 0 always ready, 1 random, otherwise held low.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       bus_if.cell_ready = 1'b1;
            1:       bus_if.cell_ready = 1'($urandom_range(0, 1));
            default: bus_if.cell_ready = 1'b0;
        endcase
    end

    // Observe reads, transfers, done pulses and held-data stability.
    always @(negedge clk) begin
        if (bus_if.vram_en === 1'b1) rd_q.push_back(bus_if.vram_addr);
        if (bus_if.vram_we !== 1'b0 || bus_if.vram_din !== 8'h00) we_bad++;
        if (done === 1'b1) done_cnt++;
        if (bus_if.cell_valid === 1'b1) vcnt++;
        if (bus_if.cell_valid === 1'b1 && prev_hold && bus_if.cell_data !== prev_data) stab_bad++;
        if (bus_if.cell_valid === 1'b1 && bus_if.cell_ready === 1'b1) begin
            rx_q.push_back(bus_if.cell_data);
`ifdef VRAM_FETCH_CURSOR_EN
            cur_q.push_back(bus_if.cell_cursor);
`endif
        end
        prev_hold = (bus_if.cell_valid === 1'b1) && (bus_if.cell_ready !== 1'b1);
        prev_data = bus_if.cell_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        done_cnt = 0;
        vcnt     = 0;
        rd_q.delete();
        rx_q.delete();
        cur_q.delete();
    endtask

    task automatic pulse_start(input logic [14:0] a, input logic [7:0] n);
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = a;
        cell_count = n;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    function automatic logic [15:0] model_cell(input logic [14:0] a, input int i);
        int p;
        p = (int'(a) % W + 2 * i) % W;
        return {mem[(p + 1) % W], mem[p]};
    endfunction

    task automatic run_fetch(input logic [14:0] a, input logic [7:0] n, input int rm, input string tag);
        int cyc;
        ready_mode = rm;
        clr();
        pulse_start(a, n);
        cyc = 0;
        while (!(done_cnt > 0 && rx_q.size() == int'(n)) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " completes"}, 32'(cyc < 2000), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " done pulses"}, done_cnt, 32'd1);
        chk({tag, " cells"}, rx_q.size(), 32'(n));
        chk({tag, " reads"}, rd_q.size(), 32'(2 * int'(n)));
        if (n == 8'd0) chk({tag, " valid cycles"}, vcnt, 32'd0);
        if (rd_q.size() == 2 * int'(n)) begin
            for (int k = 0; k < rd_q.size(); k++)
                chk($sformatf("%s rd%0d", tag, k), rd_q[k], 32'((int'(a) % W + k) % W));
        end
        if (rx_q.size() == int'(n)) begin
            for (int i = 0; i < rx_q.size(); i++)
                chk($sformatf("%s cell%0d", tag, i), rx_q[i], model_cell(a, i));
        end
    endtask

    typedef struct {
        logic [14:0] addr;
        logic [7:0]  cnt;
        int          rmode;
        int          exp_reads;
        logic [14:0] exp_first;
        logic [14:0] exp_last;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int          cyc;
        logic [14:0] ra;
        logic [7:0]  rn;

        reset_n = 1'b0;
        start = 1'b0;
        start_addr = 15'd0;
        cell_count = 8'd0;
        abort = 1'b0;
        ready_mode = 0;
        for (int i = 0; i < W; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h41;
        mem[1] = 8'h07;

        tbl[0] = '{15'h0000, 8'd1,  0, 2,  15'h0000, 15'h0001};
        tbl[1] = '{15'h1FFF, 8'd2,  0, 4,  15'h1FFF, 15'h0002};
        tbl[2] = '{15'h1FFE, 8'd1,  1, 2,  15'h1FFE, 15'h1FFF};
        tbl[3] = '{15'h7FFF, 8'd3,  1, 6,  15'h1FFF, 15'h0004};
        tbl[4] = '{15'h0100, 8'd0,  0, 0,  15'h0000, 15'h0000};
        tbl[5] = '{15'h0123, 8'd5,  1, 10, 15'h0123, 15'h012C};
        tbl[6] = '{15'h1000, 8'd20, 1, 40, 15'h1000, 15'h1027};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 32'd0);
        chk("rst done", done, 32'd0);
        chk("rst vram_en", bus_if.vram_en, 32'd0);
        chk("rst vram_addr", bus_if.vram_addr, 32'd0);
        chk("rst cell_valid", bus_if.cell_valid, 32'd0);
        chk("rst cell_data", bus_if.cell_data, 32'd0);
`ifdef VRAM_FETCH_CURSOR_EN
        bus_if.cursor_addr = 15'h0004;
        chk("rst cell_cursor", bus_if.cell_cursor, 32'd0);
`endif
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single cell, exact cycle timing
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        clr();
        pulse_start(15'h0000, 8'd1);
        @(negedge clk);
        chk("t1 en", bus_if.vram_en, 32'd1);
        chk("t1 addr", bus_if.vram_addr, 32'h0000);
        chk("t1 busy", busy, 32'd1);
        @(negedge clk);
        chk("t2 en", bus_if.vram_en, 32'd1);
        chk("t2 addr", bus_if.vram_addr, 32'h0001);
        chk("t2 valid", bus_if.cell_valid, 32'd0);
        @(negedge clk);
        chk("t3 en", bus_if.vram_en, 32'd0);
        chk("t3 valid", bus_if.cell_valid, 32'd0);
        @(negedge clk);
        chk("t4 valid", bus_if.cell_valid, 32'd1);
        chk("t4 data", bus_if.cell_data, 32'h0741);
        chk("t4 done", done, 32'd1);
        chk("t4 busy", busy, 32'd0);
        repeat (4) @(negedge clk);
        chk("t done count", done_cnt, 32'd1);
        chk("t valid after pop", bus_if.cell_valid, 32'd0);

        // Table of runs
        for (int t = 0; t < 7; t++) begin
            run_fetch(tbl[t].addr, tbl[t].cnt, tbl[t].rmode, $sformatf("tbl%0d", t));
            if (tbl[t].exp_reads > 0 && rd_q.size() == tbl[t].exp_reads) begin
                chk($sformatf("tbl%0d first", t), rd_q[0], 32'(tbl[t].exp_first));
                chk($sformatf("tbl%0d last", t), rd_q[rd_q.size() - 1], 32'(tbl[t].exp_last));
            end
        end

        // Back-pressure stall: two cells queue, no reads while stalled
        ready_mode = 2;
        clr();
        pulse_start(15'h0040, 8'd4);
        repeat (30) @(posedge clk);
        #1;
        chk("stall reads", rd_q.size(), 32'd4);
        chk("stall valid", bus_if.cell_valid, 32'd1);
        chk("stall head", bus_if.cell_data, model_cell(15'h0040, 0));
        chk("stall busy", busy, 32'd1);
        ready_mode = 0;
        cyc = 0;
        while (!(done_cnt > 0 && rx_q.size() == 4) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("stall completes", 32'(cyc < 200), 32'd1);
        chk("stall total reads", rd_q.size(), 32'd8);
        chk("stall done", done_cnt, 32'd1);
        if (rx_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("stall cell%0d", i), rx_q[i], model_cell(15'h0040, i));
        end

        // Start while busy is ignored
        ready_mode = 0;
        clr();
        pulse_start(15'h0200, 8'd3);
        @(posedge clk); #1;
        pulse_start(15'h1000, 8'd5);
        repeat (30) @(posedge clk);
        #1;
        chk("busy-start reads", rd_q.size(), 32'd6);
        chk("busy-start cells", rx_q.size(), 32'd3);
        chk("busy-start done", done_cnt, 32'd1);
        if (rd_q.size() == 6) chk("busy-start last", rd_q[5], 32'h0205);

        // Abort during ATTR of cell 3 of 10 with a cell still queued
        ready_mode = 2;
        clr();
        pulse_start(15'h0500, 8'd10);
        cyc = 0;
        while (!(rd_q.size() == 4 && bus_if.cell_valid === 1'b1) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        ready_mode = 0;
        @(posedge clk); #1;
        ready_mode = 2;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus_if.vram_en === 1'b1 && bus_if.vram_addr == 15'h0505) && cyc < 50);
        chk("abort reached attr", 32'(cyc < 50), 32'd1);
        chk("abort valid before", bus_if.cell_valid, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        chk("abort valid after", bus_if.cell_valid, 32'd0);
        chk("abort busy after", busy, 32'd0);
        chk("abort en after", bus_if.vram_en, 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort no done", done_cnt, 32'd0);
        chk("abort popped", rx_q.size(), 32'd1);
        if (rx_q.size() == 1) chk("abort cell0", rx_q[0], model_cell(15'h0500, 0));
        run_fetch(15'h0600, 8'd2, 0, "post-abort");

        // Reset asserted mid-run
        ready_mode = 0;
        clr();
        pulse_start(15'h0300, 8'd4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid-rst busy", busy, 32'd0);
        chk("mid-rst valid", bus_if.cell_valid, 32'd0);
        chk("mid-rst en", bus_if.vram_en, 32'd0);
        chk("mid-rst data", bus_if.cell_data, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid-rst no done", done_cnt, 32'd0);
        chk("mid-rst idle", busy, 32'd0);
        run_fetch(15'h0310, 8'd2, 0, "post-rst");

`ifdef VRAM_FETCH_CURSOR_EN
        // Cursor flag follows the cell at cursor_addr
        run_fetch(15'h0000, 8'd3, 0, "cursor");
        if (cur_q.size() == 3) begin
            chk("cursor0", cur_q[0], 32'd0);
            chk("cursor1", cur_q[1], 32'd0);
            chk("cursor2", cur_q[2], 32'd1);
        end
`endif

        // Random runs against the model
        for (int r = 0; r < 8; r++) begin
            ra = 15'($urandom_range(0, 32767));
            rn = 8'($urandom_range(1, 12));
            run_fetch(ra, rn, int'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        chk("held data stable", stab_bad, 32'd0);
        chk("no writes", we_bad, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
